serial_transfer_unit: RTL

SERIAL_TRANSFER_UNIT -- requirements
Module: serial_transfer_unit

---
 rtl/serial_transfer_pkg.sv | 18 +
 rtl/bit_tick_gen.sv | 48 ++++
 rtl/serial_transfer_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/serial_transfer_pkg.sv
// -----------------------------------------------------------------------------
// serial_transfer_pkg
// Shared definitions for the serial transfer unit: the FSM state encoding and
// the default parallel width / bit-clock divider.
// Optional feature macro used by the design: SERIAL_PARITY_EN
// -----------------------------------------------------------------------------
package serial_transfer_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 8;
    localparam int unsigned DEFAULT_CLK_DIV = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/bit_tick_gen.sv
// -----------------------------------------------------------------------------
// bit_tick_gen
// Divides Clk down to the serial bit rate. While i_run is high an internal
// divider counts 0..CLK_DIV-1; o_bit_end flags the last cycle of each bit and
// o_sclk_phase is high for the second half of each bit. While i_run is low the
// divider is held at zero, so every transfer starts on a fresh bit boundary.
//
// Ports:
//   i_clk        in  1  clock
//   i_rst        in  1  asynchronous active-high reset
//   i_run        in  1  divider enable (high while serializing)
//   o_bit_end    out 1  last cycle of the current bit period
//   o_sclk_phase out 1  serial clock level (low first half, high second half)
// -----------------------------------------------------------------------------
module bit_tick_gen
    import serial_transfer_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    output logic o_bit_end,
    output logic o_sclk_phase
);

    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST_DIV = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF_DIV = DW'(CLK_DIV / 2);

    logic [DW-1:0] r_div;
    logic          w_bit_end;

    assign w_bit_end    = i_run && (r_div == LAST_DIV);
    assign o_bit_end    = w_bit_end;
    assign o_sclk_phase = (r_div >= HALF_DIV);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= '0;
        end else if (!i_run || w_bit_end) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule

// File: rtl/serial_transfer_unit.sv
// -----------------------------------------------------------------------------
// serial_transfer_unit
// Captures a WIDTH-bit word and shifts it out MSB first, CLK_DIV Clk cycles
// per bit, with a mid-bit rising SerialClk. A one-cycle TransferDone pulse
// reports completion; dropping TransferData mid-word aborts silently.
// Optional feature: define SERIAL_PARITY_EN to append one even-parity bit
// after the LSB.
//
// Ports:
//   Clk          in  1      clock (rising edge)
//   Reset        in  1      asynchronous active-high reset
//   SampleData   in  1      capture request for DataIn
//   TransferData in  1      serialize request, held for the whole transfer
//   DataIn       in  WIDTH  parallel word
//   SerialOut    out 1      serial data, MSB first (idle high)
//   SerialClk    out 1      serial bit clock (idle low)
//   TransferDone out 1      one-cycle completion pulse
//   Shifting     out 1      high while a word is being serialized
// -----------------------------------------------------------------------------
module serial_transfer_unit
    import serial_transfer_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             SampleData,
    input  logic             TransferData,
    input  logic [WIDTH-1:0] DataIn,
    output logic             SerialOut,
    output logic             SerialClk,
    output logic             TransferDone,
    output logic             Shifting
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef SERIAL_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif
    // Counter stops at the last bit index instead of incrementing past it,
    // so it never needs to hold NBITS itself.
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_bitcnt;
    logic             r_serial_out;
    logic             r_serial_clk;
    logic             r_done;
    logic             r_shifting;
`ifdef SERIAL_PARITY_EN
    logic             r_parity;
`endif

    logic w_run;
    logic w_bit_end;
    logic w_sclk_phase;
    logic w_fill;

    assign w_run = (r_state == ST_SHIFT);

`ifdef SERIAL_PARITY_EN
    // Filling with the parity bit leaves it at the MSB once the LSB has gone,
    // so the parity bit is sent by the same MSB path as the data bits.
    assign w_fill = r_parity;
`else
    assign w_fill = 1'b0;
`endif

    bit_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk        (Clk),
        .i_rst        (Reset),
        .i_run        (w_run),
        .o_bit_end    (w_bit_end),
        .o_sclk_phase (w_sclk_phase)
    );

    // Outputs are registered from the current state and therefore trail it by
    // one cycle; an abort forces them idle on the same edge as the state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_serial_out <= 1'b1;
            r_serial_clk <= 1'b0;
            r_done       <= 1'b0;
            r_shifting   <= 1'b0;
`ifdef SERIAL_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_serial_out <= 1'b1;
                    r_serial_clk <= 1'b0;
                    r_shifting   <= 1'b0;
                    if (SampleData && TransferData) begin
                        r_shift  <= DataIn;
                        r_bitcnt <= '0;
                        r_state  <= ST_SHIFT;
`ifdef SERIAL_PARITY_EN
                        r_parity <= ^DataIn;
`endif
                    end
                end

                ST_SHIFT: begin
                    if (!TransferData) begin
                        r_state      <= ST_IDLE;
                        r_serial_out <= 1'b1;
                        r_serial_clk <= 1'b0;
                        r_shifting   <= 1'b0;
                    end else begin
                        r_serial_out <= r_shift[WIDTH-1];
                        r_serial_clk <= w_sclk_phase;
                        r_shifting   <= 1'b1;
                        if (w_bit_end) begin
                            r_shift <= {r_shift[WIDTH-2:0], w_fill};
                            if (r_bitcnt == LAST_BIT) begin
                                r_state <= ST_DONE;
                            end else begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    r_serial_out <= 1'b1;
                    r_serial_clk <= 1'b0;
                    r_shifting   <= 1'b0;
                    r_done       <= 1'b1;
                    r_state      <= ST_IDLE;
                end

                default: begin
                    r_serial_out <= 1'b1;
                    r_serial_clk <= 1'b0;
                    r_shifting   <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign SerialOut    = r_serial_out;
    assign SerialClk    = r_serial_clk;
    assign TransferDone = r_done;
    assign Shifting     = r_shifting;

endmodule
